ipf_engine: RTL and testbench

Parametrised 3x3 neighbourhood filter engine for the grey-image post-processing path. It fetches pixels from an asynchronous-read grey frame memory and slides a 3x3 window over every interior pixel in raster order. Each result is emitted on a valid/ready output port addressed to the same pixel index. It replaces the fixed 128x128, 8-bit, free-running filter with configurable geometry, output backpressure, a per-frame mode latch and a fourth (max) mode.

---
 rtl/ipf_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_ipf_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipf_engine.sv
// ipf_engine: parametrised 3x3 neighbourhood filter over an asynchronous-read
// grey frame memory. Slides a window over every interior pixel in raster
// order and emits one result per pixel on a valid/ready port.
// Optional feature macro: IPF_SAT_EN (clamp modes 1 and 2 instead of wrapping).
module ipf_engine #(
    parameter int DW    = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          gray_ready,
    output logic          gray_req,
    output logic [AW-1:0] gray_addr,
    input  logic [DW-1:0] gray_data,
    output logic          ipf_valid,
    input  logic          ipf_ready,
    output logic [AW-1:0] ipf_addr,
    output logic [DW-1:0] ipf_data,
    output logic          busy,
    output logic          finish
);
    localparam int XW = DW + 4;

    typedef enum logic [2:0] {IDLE, LOAD, SLIDE, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic          gray_req_q, gray_req_d;
    logic [AW-1:0] gray_addr_q, gray_addr_d;
    logic          ipf_valid_q, ipf_valid_d;
    logic [AW-1:0] ipf_addr_q, ipf_addr_d;
    logic [DW-1:0] ipf_data_q, ipf_data_d;
    logic          busy_q, busy_d;
    logic          finish_q, finish_d;

    logic [DW-1:0] result;
    logic [XW-1:0] diff;
    logic [XW-1:0] nsum;
    logic [DW-1:0] mx;
    logic          last_col;
    logic          last_row;

    function automatic logic [AW-1:0] pix_addr(input logic [AW-1:0] r, input logic [AW-1:0] c);
        logic [31:0] a;
        a = 32'(r) * 32'(IMG_W) + 32'(c);
        return a[AW-1:0];
    endfunction

    // Address of window tap k (row-major, 0..8) around centre (r,c).
    function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] r, input logic [AW-1:0] c,
                                               input logic [3:0] k);
        logic [31:0] rr;
        logic [31:0] cc;
        rr = 32'(r) + 32'(k / 4'd3) - 32'd1;
        cc = 32'(c) + 32'(k % 4'd3) - 32'd1;
        return pix_addr(rr[AW-1:0], cc[AW-1:0]);
    endfunction

    // Narrow a signed intermediate to DW bits: clamp or wrap.
    function automatic logic [DW-1:0] reduce(input logic [XW-1:0] v);
`ifdef IPF_SAT_EN
        if (v[XW-1]) return '0;
        else if (|v[XW-2:DW]) return '1;
        else return v[DW-1:0];
`else
        return v[DW-1:0];
`endif
    endfunction

    assign last_col = (col_q >= AW'(IMG_W - 2));
    assign last_row = (row_q >= AW'(IMG_H - 2));

    // Next window contents: capture reads, shift left after a mid-row handshake.
    always_comb begin
        for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
        case (state_q)
            LOAD: win_d[cnt_q] = gray_data;
            SLIDE: begin
                case (cnt_q)
                    4'd0:    win_d[2] = gray_data;
                    4'd1:    win_d[5] = gray_data;
                    default: win_d[8] = gray_data;
                endcase
            end
            WRITE: begin
                if (ipf_ready && !last_col) begin
                    win_d[0] = win_q[1];
                    win_d[1] = win_q[2];
                    win_d[3] = win_q[4];
                    win_d[4] = win_q[5];
                    win_d[6] = win_q[7];
                    win_d[7] = win_q[8];
                end
            end
            default: ;
        endcase
    end

    // Filter result from the window as it will stand after this cycle's capture.
    always_comb begin
        result = '0;
        diff   = '0;
        nsum   = '0;
        mx     = win_d[0];
        case (mode_q)
            2'd0: begin
                for (int k = 0; k < 8; k++) result[k] = (win_d[(k < 4) ? k : k + 1] >= win_d[4]);
            end
            2'd1: begin
                diff   = XW'(win_d[4] >> 1) - XW'(win_d[8] >> 1);
                result = reduce(diff);
            end
            2'd2: begin
                for (int k = 0; k < 9; k++) if (k != 4) nsum = nsum + XW'(win_d[k] >> 3);
                diff   = XW'(win_d[4]) - nsum;
                result = reduce(diff);
            end
            default: begin
                for (int k = 1; k < 9; k++) if (win_d[k] > mx) mx = win_d[k];
                result = mx;
            end
        endcase
    end

    // Frame sequencing: start acceptance, read addressing, result handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        mode_d      = mode_q;
        gray_req_d  = gray_req_q;
        gray_addr_d = gray_addr_q;
        ipf_valid_d = ipf_valid_q;
        ipf_addr_d  = ipf_addr_q;
        ipf_data_d  = ipf_data_q;
        busy_d      = busy_q;
        finish_d    = finish_q;
        case (state_q)
            IDLE, DONE: begin
                if (start && gray_ready) begin
                    mode_d      = mode;
                    row_d       = AW'(1);
                    col_d       = AW'(1);
                    cnt_d       = '0;
                    gray_req_d  = 1'b1;
                    gray_addr_d = '0;
                    busy_d      = 1'b1;
                    finish_d    = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (cnt_q == 4'd8) begin
                    state_d     = WRITE;
                    gray_req_d  = 1'b0;
                    ipf_valid_d = 1'b1;
                    ipf_addr_d  = pix_addr(row_q, col_q);
                    ipf_data_d  = result;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    gray_addr_d = win_addr(row_q, col_q, cnt_q + 4'd1);
                end
            end
            SLIDE: begin
                if (cnt_q == 4'd2) begin
                    state_d     = WRITE;
                    gray_req_d  = 1'b0;
                    ipf_valid_d = 1'b1;
                    ipf_addr_d  = pix_addr(row_q, col_q);
                    ipf_data_d  = result;
                end else begin
                    cnt_d       = cnt_q + 4'd1;
                    gray_addr_d = gray_addr_q + AW'(IMG_W);
                end
            end
            WRITE: begin
                if (ipf_ready) begin
                    ipf_valid_d = 1'b0;
                    ipf_data_d  = '0;
                    cnt_d       = '0;
                    if (!last_col) begin
                        col_d       = col_q + AW'(1);
                        state_d     = SLIDE;
                        gray_req_d  = 1'b1;
                        gray_addr_d = pix_addr(row_q - AW'(1), col_q + AW'(2));
                    end else if (!last_row) begin
                        row_d       = row_q + AW'(1);
                        col_d       = AW'(1);
                        state_d     = LOAD;
                        gray_req_d  = 1'b1;
                        gray_addr_d = pix_addr(row_q, {AW{1'b0}});
                    end else begin
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        finish_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mode_q      <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            ipf_valid_q <= 1'b0;
            ipf_addr_q  <= '0;
            ipf_data_q  <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            mode_q      <= mode_d;
            for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            ipf_valid_q <= ipf_valid_d;
            ipf_addr_q  <= ipf_addr_d;
            ipf_data_q  <= ipf_data_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
        end
    end

    assign gray_req  = gray_req_q;
    assign gray_addr = gray_addr_q;
    assign ipf_valid = ipf_valid_q;
    assign ipf_addr  = ipf_addr_q;
    assign ipf_data  = ipf_data_q;
    assign busy      = busy_q;
    assign finish    = finish_q;

endmodule

// File: tb/tb_ipf_engine.sv
// tb_ipf_engine: scoreboard bench for ipf_engine on a 4x4 image.
// Expected results come from a per-pixel reference model over the image array.
module tb_ipf_engine;
    localparam int DW           = 8;
    localparam int IMG_W        = 4;
    localparam int IMG_H        = 4;
    localparam int AW           = 4;
    localparam int NPIX         = IMG_W * IMG_H;
    localparam int FRAME_CYCLES = (IMG_H - 2) * (10 + 4 * (IMG_W - 3));

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic          gray_ready;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [DW-1:0] gray_data;
    logic          ipf_valid;
    logic          ipf_ready = 1'b1;
    logic [AW-1:0] ipf_addr;
    logic [DW-1:0] ipf_data;
    logic          busy;
    logic          finish;

    logic [DW-1:0] mem [NPIX];

    typedef struct {
        int addr;
        int data;
        int hs_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int hs_count    = 0;
    int last_hs     = 0;
    int stall_left  = 0;
    int ready_mode  = 0;
    logic          stalled     = 1'b0;
    logic          finish_prev = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    ipf_engine #(
        .DW   (DW),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .AW   (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .gray_ready(gray_ready),
        .gray_req  (gray_req),
        .gray_addr (gray_addr),
        .gray_data (gray_data),
        .ipf_valid (ipf_valid),
        .ipf_ready (ipf_ready),
        .ipf_addr  (ipf_addr),
        .ipf_data  (ipf_data),
        .busy      (busy),
        .finish    (finish)
    );

    assign gray_data = mem[gray_addr];

    always #5 clk = ~clk;

    // Edge counter used to timestamp handshakes and frame completion.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int reduce_ref(input int v);
`ifdef IPF_SAT_EN
        if (v < 0) return 0;
        if (v > (1 << DW) - 1) return (1 << DW) - 1;
        return v;
`else
        return v & ((1 << DW) - 1);
`endif
    endfunction

    // Reference filter evaluated straight from the image around pixel (r,c).
    function automatic int ref_pixel(input int m, input int r, input int c);
        int cen, v, bitpos, n, sum;
        cen = int'(mem[r * IMG_W + c]);
        v = 0;
        bitpos = 0;
        sum = 0;
        case (m)
            0: begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0)) begin
                            n = int'(mem[(r + dr) * IMG_W + c + dc]);
                            if (n >= cen) v = v | (1 << bitpos);
                            bitpos++;
                        end
            end
            1: v = reduce_ref(cen / 2 - int'(mem[(r + 1) * IMG_W + c + 1]) / 2);
            2: begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0)) sum += int'(mem[(r + dr) * IMG_W + c + dc]) / 8;
                v = reduce_ref(cen - sum);
            end
            default: begin
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (int'(mem[(r + dr) * IMG_W + c + dc]) > v) v = int'(mem[(r + dr) * IMG_W + c + dc]);
            end
        endcase
        return v;
    endfunction

    // Queue the whole frame's results; with ready held high also predict handshake edges.
    task automatic pushFrame(input int m, input int accept, input bit timed);
        int t;
        exp_t e;
        t = accept;
        for (int r = 1; r <= IMG_H - 2; r++)
            for (int c = 1; c <= IMG_W - 2; c++) begin
                t += (c == 1) ? 10 : 4;
                e.addr    = r * IMG_W + c;
                e.data    = ref_pixel(m, r, c);
                e.hs_edge = timed ? t : -1;
                exp_q.push_back(e);
            end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " gray_req"}, gray_req, 0);
        checkOutput({tag, " gray_addr"}, gray_addr, 0);
        checkOutput({tag, " ipf_valid"}, ipf_valid, 0);
        checkOutput({tag, " ipf_addr"}, ipf_addr, 0);
        checkOutput({tag, " ipf_data"}, ipf_data, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " finish"}, finish, 0);
    endtask

    task automatic fillConst(input int v);
        for (int k = 0; k < NPIX; k++) mem[k] = DW'(v);
    endtask

    task automatic fillRamp();
        for (int k = 0; k < NPIX; k++) mem[k] = DW'(k);
    endtask

    task automatic fillRandom();
        for (int k = 0; k < NPIX; k++) mem[k] = DW'($urandom);
    endtask

    // Run one frame: start it, queue expectations, wait for finish with a bound.
    task automatic applyStimulus(input int m, input int rmode, input int exp_len, input bit bump);
        int accept, n;
        ready_mode = rmode;
        stall_left = 5;
        hs_count   = 0;
        @(posedge clk);
        #2;
        mode       = 2'(m);
        gray_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        accept = cyc;
        start  = 1'b0;
        mode   = 2'($urandom_range(0, 3));
        pushFrame(m, accept, rmode == 0);
        checkOutput("busy after start", busy, 1);
        if (bump) begin
            repeat (4) @(posedge clk);
            #2;
            start = 1'b1;
            mode  = 2'(m ^ 1);
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        n = 0;
        while (!finish && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame completed", finish, 1);
        if (exp_len >= 0) checkOutput("frame length", cyc - accept, exp_len);
        checkOutput("busy at finish", busy, 0);
        checkOutput("results drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Consumer: ready always high, random, or held low for 5 cycles on the second result.
    always @(posedge clk) begin
        #2;
        if (ready_mode == 0) ipf_ready = 1'b1;
        else if (ready_mode == 1) ipf_ready = ($urandom_range(0, 3) != 0);
        else if (ipf_valid && hs_count == 1 && stall_left > 0) begin
            ipf_ready = 1'b0;
            stall_left--;
        end else ipf_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stalled     = 1'b0;
            finish_prev = 1'b0;
        end else begin
            if (ipf_valid) begin
                if (!ipf_ready) begin
                    checkOutput("gray_req during stall", gray_req, 0);
                    if (stalled) begin
                        checkOutput("stall ipf_addr hold", ipf_addr, hold_addr);
                        checkOutput("stall ipf_data hold", ipf_data, hold_data);
                    end else begin
                        stalled   = 1'b1;
                        hold_addr = ipf_addr;
                        hold_data = ipf_data;
                    end
                end else begin
                    if (stalled) begin
                        checkOutput("release ipf_addr hold", ipf_addr, hold_addr);
                        checkOutput("release ipf_data hold", ipf_data, hold_data);
                    end
                    stalled = 1'b0;
                    checkOutput("result expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        mon_e = exp_q.pop_front();
                        checkOutput("ipf_addr", ipf_addr, mon_e.addr);
                        checkOutput("ipf_data", ipf_data, mon_e.data);
                        if (mon_e.hs_edge >= 0) checkOutput("handshake cycle", cyc + 1, mon_e.hs_edge);
                    end
                    hs_count++;
                    last_hs = cyc + 1;
                end
            end else begin
                checkOutput("ipf_data while idle", ipf_data, 0);
            end
            if (finish && !finish_prev) checkOutput("finish after last handshake", cyc, last_hs);
            finish_prev = finish;
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized frames.
    initial begin
        int accept;
        reset      = 1'b1;
        start      = 1'b0;
        mode       = 2'd0;
        gray_ready = 1'b0;
        fillConst(0);
        repeat (3) @(posedge clk);
        #2;
        checkReset("power-on");
        reset = 1'b0;

        @(posedge clk);
        #2;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy without gray_ready", busy, 0);
        checkOutput("gray_req without gray_ready", gray_req, 0);

        fillRamp();
        applyStimulus(3, 0, FRAME_CYCLES, 1'b0);

        fillConst(0);
        mem[IMG_W + 1]     = 8'd200;
        mem[2 * IMG_W + 2] = 8'd50;
        applyStimulus(1, 0, FRAME_CYCLES, 1'b0);

        fillConst(0);
        mem[IMG_W + 1]     = 8'd10;
        mem[2 * IMG_W + 2] = 8'd200;
        applyStimulus(1, 0, FRAME_CYCLES, 1'b0);

        fillConst(255);
        mem[IMG_W + 1] = 8'd8;
        applyStimulus(2, 0, FRAME_CYCLES, 1'b0);

        fillConst(0);
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) mem[dr * IMG_W + dc] = DW'(1 + dr * 3 + dc);
        applyStimulus(0, 0, FRAME_CYCLES, 1'b0);

        fillRandom();
        applyStimulus(2, 2, FRAME_CYCLES + 5, 1'b0);

        fillRamp();
        ready_mode = 0;
        @(posedge clk);
        #2;
        mode       = 2'd3;
        gray_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        accept = cyc;
        start  = 1'b0;
        pushFrame(3, accept, 1'b1);
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkReset("mid-frame reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("idle after reset", busy, 0);
        checkOutput("no output after reset", ipf_valid, 0);

        applyStimulus(3, 0, FRAME_CYCLES, 1'b1);

        for (int f = 0; f < 12; f++) begin
            fillRandom();
            applyStimulus(int'($urandom_range(0, 3)), 1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
